// File: rtl/window_seq_if.sv
// Pixel-in / window-out handshake bundle for window_seq_ctrl.
// The master drives the pixel stream and the downstream ready; the slave is the controller.
interface window_seq_if #(
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             shift;
  logic             out_ready;
  logic             win_valid;
  logic [CNT_W-1:0] win_x;
  logic [CNT_W-1:0] win_y;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output in_valid, in_sof, out_ready,
    input  in_ready, shift, win_valid, win_x, win_y, frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, out_ready,
    output in_ready, shift, win_valid, win_x, win_y, frame_done, sof_err
  );
endinterface

// File: rtl/window_seq_ctrl.sv
// Raster sequencer for the line-buffer/window datapath: drives the shared shift enable and
// flags complete windows with centre coordinates. Define SOF_RESYNC_EN to restart on a mid-frame in_sof.
module window_seq_ctrl #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int WIN_SIZE   = 5,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  window_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] EDGE   = CNT_W'(WIN_SIZE - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'((WIN_SIZE - 1) / 2);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] x, y, x_next, y_next;
  logic             in_ready, accept, streaming, resync, qualify;
  logic             win_valid, frame_sof_err;
  logic [CNT_W-1:0] win_x, win_y;

  assign streaming = (state == PRIME) || (state == RUN);
  assign in_ready  = (state == IDLE) || (streaming && bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

`ifdef SOF_RESYNC_EN
  assign resync = accept && streaming && bus.in_sof;
`else
  assign resync = 1'b0;
`endif

  // x/y name the pixel being accepted now; a window is complete once it lies WIN_SIZE-1 deep in both axes.
  assign qualify = accept && streaming && !resync && (x >= EDGE) && (y >= EDGE);

  assign bus.in_ready   = in_ready;
  assign bus.shift      = accept && ((state != IDLE) || bus.in_sof);
  assign bus.frame_done = (state == DONE);
  assign bus.win_valid  = win_valid;
  assign bus.win_x      = win_x;
  assign bus.win_y      = win_y;
  assign bus.sof_err    = frame_sof_err;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
    state_next = state;
    x_next     = x;
    y_next     = y;
    case (state)
      IDLE: begin
        if (accept && bus.in_sof) begin
          x_next     = ONE;
          y_next     = '0;
          state_next = PRIME;
        end
      end
      PRIME, RUN: begin
        if (resync) begin
          x_next     = ONE;
          y_next     = '0;
          state_next = PRIME;
        end else if (accept) begin
          if (x == X_LAST) begin
            x_next = '0;
            y_next = y + ONE;
            if ((state == PRIME) && (y + ONE == EDGE)) state_next = RUN;
            if ((state == RUN) && (y == Y_LAST)) begin
              y_next     = '0;
              state_next = DONE;
            end
          end else begin
            x_next = x + ONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
    end
  end

  // A window holds while the kernel stalls; no shift can happen then, so the buffers stay frozen too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid     <= 1'b0;
      win_x         <= '0;
      win_y         <= '0;
      frame_sof_err <= 1'b0;
    end else begin
      if (qualify) begin
        win_valid <= 1'b1;
        win_x     <= x - HALF;
        win_y     <= y - HALF;
      end else if (bus.out_ready) begin
        win_valid <= 1'b0;
      end
      frame_sof_err <= accept && bus.in_sof && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Directed bench for window_seq_ctrl on an 8x6 image with a 3x3 window.
// Windows are logged at the negedge monitor and checked in raster order after each frame.
module tb_window_seq_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WS = 3;
  localparam int CW = 4;
  localparam int WIN_PER_ROW   = W - WS + 1;
  localparam int WIN_PER_FRAME = (W - WS + 1) * (H - WS + 1);
  localparam int FIRST_SHIFTS  = W * (WS - 1) + WS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_seq_if #(.CNT_W(CW)) bus ();

  window_seq_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .WIN_SIZE  (WS),
    .CNT_W     (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int x;
    int y;
    int shifts;
  } win_rec_t;

  win_rec_t   win_log[$];
  logic [9:0] done_log[$];
  int shift_cnt = 0;
  int done_cnt  = 0;
  int sof_cnt   = 0;

  int checks   = 0;
  int failures = 0;
  int win_base, shift_base, done_base, sof_base;

  always @(negedge clk) begin
    if (bus.win_valid && bus.out_ready)
      win_log.push_back('{int'(bus.win_x), int'(bus.win_y), shift_cnt});
    if (bus.frame_done) begin
      done_cnt++;
      done_log.push_back({bus.win_valid, bus.in_ready, bus.win_x, bus.win_y});
    end
    if (bus.shift)   shift_cnt++;
    if (bus.sof_err) sof_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_pixel(input bit sof);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int sof_idx, input bit bubbles);
    for (int i = lo; i <= hi; i++) begin
      if (bubbles && ($urandom_range(1) == 1)) begin
        @(posedge clk);
        #1;
      end
      send_pixel(i == sof_idx);
    end
  endtask

  task automatic begin_frame();
    win_base   = win_log.size();
    shift_base = shift_cnt;
    done_base  = done_cnt;
    sof_base   = sof_cnt;
  endtask

  task automatic check_windows(input string tag, input int n);
    int got;
    got = win_log.size() - win_base;
    check({tag, "_win_count"}, 32'(got), 32'(n));
    for (int i = 0; i < got && i < n; i++) begin
      check($sformatf("%s_win%0d_xy", tag, i),
            32'((win_log[win_base + i].x << 8) | win_log[win_base + i].y),
            32'(((1 + i % WIN_PER_ROW) << 8) | (1 + i / WIN_PER_ROW)));
      if (i == 0)
        check({tag, "_first_win_shifts"}, 32'(win_log[win_base].shifts - shift_base),
              32'(FIRST_SHIFTS));
    end
  endtask

  task automatic end_frame(input string tag, input int exp_sof);
    repeat (4) @(posedge clk);
    #1;
    check_windows(tag, WIN_PER_FRAME);
    check({tag, "_shifts"}, 32'(shift_cnt - shift_base), 32'(W * H));
    check({tag, "_frame_done"}, 32'(done_cnt - done_base), 32'd1);
    if (done_log.size() > 0)
      check({tag, "_last_win_at_done"}, 32'(done_log[done_log.size() - 1]),
            32'({2'b10, 4'd6, 4'd4}));
    check({tag, "_sof_err"}, 32'(sof_cnt - sof_base), 32'(exp_sof));
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          32'({bus.in_ready, bus.shift, bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err}),
          32'(13'h1000));
    rst_n = 1'b1;

    // Pixels without in_sof in IDLE are accepted but never shifted.
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("discard_ready_shift", 32'({bus.in_ready, bus.shift}), 32'(2'b10));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    begin_frame();
    send_range(0, W * H - 1, 0, 1'b0);
    end_frame("cont", 0);

    // Stall the kernel while the window centred at (3,2) is presented.
    begin_frame();
    send_range(0, 28, 0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_hold",
            32'({bus.in_ready, bus.shift, bus.win_valid, bus.win_x, bus.win_y}),
            32'({3'b001, 4'd3, 4'd2}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_range(29, W * H - 1, -1, 1'b0);
    end_frame("stall", 0);

    begin_frame();
    send_range(0, W * H - 1, 0, 1'b1);
    end_frame("bubble", 0);

    // in_sof on pixel (5,3).
    begin_frame();
    send_range(0, 28, 0, 1'b0);
    send_pixel(1'b1);
`ifdef SOF_RESYNC_EN
    check_windows("abort", 9);
    win_base   = win_log.size();
    shift_base = shift_cnt - 1;
    send_range(1, 18, -1, 1'b0);
    check("resync_gap", 32'(win_log.size() - win_base), 32'd0);
    send_range(19, W * H - 1, -1, 1'b0);
`else
    send_range(30, W * H - 1, -1, 1'b0);
`endif
    end_frame("sof", 1);

    // Reset while pixel (4,4) is offered, then a clean frame.
    begin_frame();
    send_range(0, 35, 0, 1'b0);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("in_reset_outputs",
            32'({bus.shift, bus.win_valid, bus.win_x, bus.win_y, bus.frame_done, bus.sof_err}),
            32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    begin_frame();
    send_range(0, W * H - 1, 0, 1'b0);
    end_frame("post_reset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
